// File: rtl/data_stream_checker.sv
// Receive-side checker for the Data_Gen Valid/Data stream. It locks onto the
// incrementing symbol sequence, counts mismatches and frames, and drops lock after repeated errors.
module data_stream_checker #(
    parameter int DATA_SIZE = 4,
    parameter int DATA_NUM  = 16,
    parameter int LOCK_THR  = 4,
    parameter int LOSS_THR  = 3,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 Valid,
    input  logic [DATA_SIZE-1:0] Data,
    input  logic                 Stop4calc,
    output logic                 Locked,
    output logic                 Err,
    output logic [CNT_SIZE-1:0]  Err_cnt,
    output logic                 Frame_done,
    output logic [CNT_SIZE-1:0]  Frame_cnt,
    output logic                 Lost
);

    localparam int GW = $clog2(LOCK_THR + 1);
    localparam int BW = $clog2(LOSS_THR + 1);
    localparam int IW = $clog2(DATA_NUM + 1);

    localparam logic [GW-1:0]        LOCK_V   = GW'(LOCK_THR);
    localparam logic [BW-1:0]        LOSS_V   = BW'(LOSS_THR);
    localparam logic [IW-1:0]        FRAME_V  = IW'(DATA_NUM);
    localparam logic [GW-1:0]        G_ONE    = GW'(1'b1);
    localparam logic [BW-1:0]        B_ONE    = BW'(1'b1);
    localparam logic [IW-1:0]        I_ONE    = IW'(1'b1);
    localparam logic [DATA_SIZE-1:0] D_ONE    = DATA_SIZE'(1'b1);
    localparam logic [CNT_SIZE-1:0]  C_ONE    = CNT_SIZE'(1'b1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_SIZE-1:0]  expected_r, expected_s;
    logic [GW-1:0]         good_run_r, good_run_s;
    logic [BW-1:0]         bad_run_r, bad_run_s;
    logic [IW-1:0]         sym_idx_r, sym_idx_s;
    logic [CNT_SIZE-1:0]   err_cnt_r, err_cnt_s;
    logic [CNT_SIZE-1:0]   frame_cnt_r, frame_cnt_s;
    logic                  locked_r, locked_s;
    logic                  err_r, err_s;
    logic                  frame_done_r, frame_done_s;
    logic                  lost_r, lost_s;
    logic                  accept_s;

    function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + C_ONE;
        end
    endfunction

    assign accept_s = Valid & ~Stop4calc;

    // Next-state and next-output decode for one accepted symbol.
    always_comb begin
        state_s      = state_r;
        expected_s   = expected_r;
        good_run_s   = good_run_r;
        bad_run_s    = bad_run_r;
        sym_idx_s    = sym_idx_r;
        err_cnt_s    = err_cnt_r;
        frame_cnt_s  = frame_cnt_r;
        err_s        = 1'b0;
        frame_done_s = 1'b0;
        lost_s       = 1'b0;
        if (accept_s) begin
            case (state_r)
                HUNT: begin
                    expected_s = Data + D_ONE;
                    if ((Data == expected_r) && (good_run_r != {GW{1'b0}})) begin
                        good_run_s = good_run_r + G_ONE;
                        if ((good_run_r + G_ONE) == LOCK_V) begin
                            state_s   = LOCKED;
                            sym_idx_s = {IW{1'b0}};
                            bad_run_s = {BW{1'b0}};
                        end else begin
                            state_s = HUNT;
                        end
                    end else begin
                        good_run_s = G_ONE;
                    end
                end
                LOCKED: begin
                    // Expected advances even on a mismatch so one corrupt symbol is tolerated.
                    expected_s = expected_r + D_ONE;
                    if ((sym_idx_r + I_ONE) == FRAME_V) begin
                        sym_idx_s    = {IW{1'b0}};
                        frame_done_s = 1'b1;
                        frame_cnt_s  = frame_cnt_r + C_ONE;
                    end else begin
                        sym_idx_s = sym_idx_r + I_ONE;
                    end
                    if (Data != expected_r) begin
                        err_s     = 1'b1;
                        err_cnt_s = sat_inc(err_cnt_r);
                        if ((bad_run_r + B_ONE) == LOSS_V) begin
                            state_s    = HUNT;
                            lost_s     = 1'b1;
                            good_run_s = {GW{1'b0}};
                            sym_idx_s  = {IW{1'b0}};
                            bad_run_s  = {BW{1'b0}};
                        end else begin
                            bad_run_s = bad_run_r + B_ONE;
                        end
                    end else begin
                        bad_run_s = {BW{1'b0}};
                    end
                end
                default: begin
                    state_s = HUNT;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        locked_s = (state_s == LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= HUNT;
            expected_r   <= {DATA_SIZE{1'b0}};
            good_run_r   <= {GW{1'b0}};
            bad_run_r    <= {BW{1'b0}};
            sym_idx_r    <= {IW{1'b0}};
            err_cnt_r    <= {CNT_SIZE{1'b0}};
            frame_cnt_r  <= {CNT_SIZE{1'b0}};
            locked_r     <= 1'b0;
            err_r        <= 1'b0;
            frame_done_r <= 1'b0;
            lost_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            expected_r   <= expected_s;
            good_run_r   <= good_run_s;
            bad_run_r    <= bad_run_s;
            sym_idx_r    <= sym_idx_s;
            err_cnt_r    <= err_cnt_s;
            frame_cnt_r  <= frame_cnt_s;
            locked_r     <= locked_s;
            err_r        <= err_s;
            frame_done_r <= frame_done_s;
            lost_r       <= lost_s;
        end
    end

    assign Locked     = locked_r;
    assign Err        = err_r;
    assign Err_cnt    = err_cnt_r;
    assign Frame_done = frame_done_r;
    assign Frame_cnt  = frame_cnt_r;
    assign Lost       = lost_r;

endmodule

// File: tb/tb_data_stream_checker.sv
// Bench for data_stream_checker: directed vector table, reset/saturation sequences,
// and random stream compared against a queue-based reference model.
module tb_data_stream_checker;

    logic       clk;
    logic       rstn;
    logic       valid;
    logic       stop;
    logic [3:0] data;

    logic        locked, err, frame_done, lost;
    logic [15:0] err_cnt, frame_cnt;
    logic        s_locked, s_err, s_frame_done, s_lost;
    logic [3:0]  s_err_cnt, s_frame_cnt;

    int total;
    int bad;

    data_stream_checker #(.DATA_SIZE(4), .DATA_NUM(16), .LOCK_THR(4), .LOSS_THR(3), .CNT_SIZE(16)) dut (
        .clk(clk), .rstn(rstn), .Valid(valid), .Data(data), .Stop4calc(stop),
        .Locked(locked), .Err(err), .Err_cnt(err_cnt),
        .Frame_done(frame_done), .Frame_cnt(frame_cnt), .Lost(lost)
    );

    data_stream_checker #(.DATA_SIZE(4), .DATA_NUM(16), .LOCK_THR(4), .LOSS_THR(3), .CNT_SIZE(4)) dut_small (
        .clk(clk), .rstn(rstn), .Valid(valid), .Data(data), .Stop4calc(stop),
        .Locked(s_locked), .Err(s_err), .Err_cnt(s_err_cnt),
        .Frame_done(s_frame_done), .Frame_cnt(s_frame_cnt), .Lost(s_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic [3:0] d;
        logic       l;
        logic       e;
        logic       f;
        logic       x;
        int         ec;
        int         fc;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic v, input logic s, input int d, input logic l, input logic e,
                       input logic f, input logic x, input int ec, input int fc);
        vec_t r;
        r.v = v; r.s = s; r.d = 4'(d); r.l = l; r.e = e; r.f = f; r.x = x; r.ec = ec; r.fc = fc;
        tab.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic s, input logic [3:0] d);
        valid = v;
        stop  = s;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: lock when LOCK_THR consecutive symbols form a +1 chain,
    // then compare against a free-running expected value.
    bit  m_locked;
    int  hq[$];
    int  m_exp, m_pos, m_miss, m_errs, m_frames;
    bit  m_err, m_fd, m_lost;

    task automatic model_reset();
        m_locked = 1'b0; hq.delete();
        m_exp = 0; m_pos = 0; m_miss = 0; m_errs = 0; m_frames = 0;
        m_err = 1'b0; m_fd = 1'b0; m_lost = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input int d);
        m_err = 1'b0; m_fd = 1'b0; m_lost = 1'b0;
        if (v && !s) begin
            if (!m_locked) begin
                if (hq.size() > 0 && d == (hq[$] + 1) % 16) begin
                    hq.push_back(d);
                end else begin
                    hq.delete();
                    hq.push_back(d);
                end
                m_exp = (d + 1) % 16;
                if (hq.size() == 4) begin
                    m_locked = 1'b1; m_pos = 0; m_miss = 0; hq.delete();
                end
            end else begin
                bit wrong;
                wrong = (d != m_exp);
                m_exp = (m_exp + 1) % 16;
                m_pos++;
                if (m_pos == 16) begin
                    m_fd = 1'b1; m_frames++; m_pos = 0;
                end
                if (wrong) begin
                    m_err = 1'b1; m_errs++; m_miss++;
                    if (m_miss == 3) begin
                        m_lost = 1'b1; m_locked = 1'b0; hq.delete(); m_pos = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        int exp_d;
        int gen;
        int pct;
        logic       rv, rs;
        logic [3:0] rd;
        logic [35:0] exp_main;
        logic [11:0] exp_small;

        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        valid = 1'b0;
        stop  = 1'b0;
        data  = 4'd0;

        // Reset held with live symbols: nothing may move.
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 4'(i % 3));
            check($sformatf("reset_hold[%0d]", i),
                  64'({locked, err, frame_done, lost, err_cnt, frame_cnt}), 64'd0);
        end
        rstn = 1'b1;

        // Directed vectors: lock, frame wrap, single error, stall, loss, relock, frame+loss.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add(1, 0, (4 + i) % 16, 1, 0, (i == 15), 0, 0, (i == 15) ? 1 : 0);
        add(1, 0, 4, 1, 0, 0, 0, 0, 1);
        add(1, 0, 5, 1, 0, 0, 0, 0, 1);
        add(1, 0, 6, 1, 0, 0, 0, 0, 1);
        add(1, 0, 9, 1, 1, 0, 0, 1, 1);
        add(1, 0, 8, 1, 0, 0, 0, 1, 1);
        add(1, 0, 9, 1, 0, 0, 0, 1, 1);
        add(1, 1, 10, 1, 0, 0, 0, 1, 1);
        add(1, 1, 11, 1, 0, 0, 0, 1, 1);
        add(1, 0, 12, 1, 1, 0, 0, 2, 1);
        add(1, 0, 11, 1, 0, 0, 0, 2, 1);
        add(0, 0, 5, 1, 0, 0, 0, 2, 1);
        add(1, 0, 0, 1, 1, 0, 0, 3, 1);
        add(1, 0, 0, 1, 1, 0, 0, 4, 1);
        add(1, 0, 0, 0, 1, 0, 1, 5, 1);
        add(1, 0, 7, 0, 0, 0, 0, 5, 1);
        add(1, 0, 8, 0, 0, 0, 0, 5, 1);
        add(1, 0, 9, 0, 0, 0, 0, 5, 1);
        add(1, 0, 10, 1, 0, 0, 0, 5, 1);
        for (int i = 0; i < 13; i++)
            add(1, 0, (11 + i) % 16, 1, 0, 0, 0, 5, 1);
        add(1, 0, 0, 1, 1, 0, 0, 6, 1);
        add(1, 0, 0, 1, 1, 0, 0, 7, 1);
        add(1, 0, 0, 0, 1, 1, 1, 8, 2);

        foreach (tab[i]) begin
            apply(tab[i].v, tab[i].s, tab[i].d);
            check($sformatf("vec[%0d]", i),
                  64'({locked, err, frame_done, lost, err_cnt, frame_cnt}),
                  64'({tab[i].l, tab[i].e, tab[i].f, tab[i].x, 16'(tab[i].ec), 16'(tab[i].fc)}));
        end

        // Asynchronous reset mid-cycle clears counters immediately.
        valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_main", 64'({locked, err, frame_done, lost, err_cnt, frame_cnt}), 64'd0);
        check("async_reset_small", 64'({s_locked, s_err, s_frame_done, s_lost, s_err_cnt, s_frame_cnt}), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Saturation of the narrow error counter with isolated mismatches.
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 4'(i));
        check("sat_lock", 64'(s_locked), 64'd1);
        exp_d = 4;
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, 1'b0, 4'(exp_d ^ 8));
            check($sformatf("sat_err[%0d]", k), 64'({s_err, s_err_cnt, err}),
                  64'({1'b1, 4'(min_int(k + 1, 15)), 1'b1}));
            exp_d = (exp_d + 1) % 16;
            apply(1'b1, 1'b0, 4'(exp_d));
            exp_d = (exp_d + 1) % 16;
        end
        check("sat_final", 64'({s_locked, s_err_cnt, err_cnt}), 64'({1'b1, 4'd15, 16'd20}));

        // Random stream against the reference model.
        rstn = 1'b0;
        apply(1'b0, 1'b0, 4'd0);
        rstn = 1'b1;
        model_reset();
        gen = $urandom_range(0, 15);
        for (int i = 0; i < 3000; i++) begin
            pct = ((i / 200) % 2 == 1) ? 50 : 5;
            rv = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 4) == 0);
            rd = ($urandom_range(0, 99) < pct) ? 4'($urandom_range(0, 15)) : 4'(gen);
            if (rv && !rs) gen = (gen + 1) % 16;
            model_step(rv, rs, int'(rd));
            apply(rv, rs, rd);
            exp_main  = {m_locked, m_err, m_fd, m_lost, 16'(min_int(m_errs, 65535)), 16'(m_frames % 65536)};
            exp_small = {m_locked, m_err, m_fd, m_lost, 4'(min_int(m_errs, 15)), 4'(m_frames % 16)};
            check($sformatf("rand_main[%0d]", i),
                  64'({locked, err, frame_done, lost, err_cnt, frame_cnt}), 64'(exp_main));
            check($sformatf("rand_small[%0d]", i),
                  64'({s_locked, s_err, s_frame_done, s_lost, s_err_cnt, s_frame_cnt}), 64'(exp_small));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_stream_checker.md
Name: data_stream_checker

Overview:
- Receive-side checker for the Data_Gen Valid/Data stream in the clk200 domain; taps the same Valid/Data pair that feeds Frotaegis_Design.
- Locks onto the incrementing symbol sequence and then checks every accepted symbol against the expected value.
- Counts errors and completed frames of DATA_NUM symbols, and drops lock after repeated mismatches.
- Holds its state while the design back-pressures with Stop4calc.

Parameters:
DATA_SIZE, 4, symbol width in bits; the sequence wraps mod 2^DATA_SIZE
DATA_NUM, 16, symbols per frame; must be >= 2
LOCK_THR, 4, consecutive in-sequence symbols required to acquire lock; must be >= 2
LOSS_THR, 3, consecutive mismatches while locked that drop lock; must be >= 1
CNT_SIZE, 16, width of Err_cnt and Frame_cnt

Ports:
clk  input  1  clk200 domain clock
rstn  input  1  asynchronous active-low reset
Valid  input  1  symbol strobe from Data_Gen
Data  input  DATA_SIZE  symbol from Data_Gen
Stop4calc  input  1  back-pressure from Frotaegis_Design; while high, symbols are ignored
Locked  output  1  high while in LOCKED
Err  output  1  one-cycle pulse on each mismatch while locked
Err_cnt  output  CNT_SIZE  saturating count of mismatches while locked
Frame_done  output  1  one-cycle pulse when a frame completes while locked
Frame_cnt  output  CNT_SIZE  wrapping count of completed frames
Lost  output  1  one-cycle pulse on the LOCKED->HUNT transition

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: all outputs 0, state HUNT, all internal counters 0, Expected 0.
- Accept rule: a symbol is accepted on a rising clk edge where Valid=1 and Stop4calc=0.
  - On cycles with no accepted symbol, all state and counters hold and all pulses are 0.
- Latency: every output is registered. The response to a symbol accepted at edge N is visible after edge N, i.e. one cycle later.
- Expected tracking:
  - Expected <= Data+1 in HUNT.
  - Expected <= Expected+1 in LOCKED, whether the symbol matched or not, so an isolated corrupt symbol is tolerated.
  - All arithmetic is mod 2^DATA_SIZE; the wrap 2^DATA_SIZE-1 -> 0 counts as in-sequence.
- State HUNT:
  - Match is Data==Expected and good_run>0.
  - On a match, good_run++. Otherwise good_run <= 1, i.e. the current symbol seeds a new run.
  - When good_run would reach LOCK_THR: go to LOCKED, Locked=1, sym_idx <= 0, bad_run <= 0.
  - The locking symbol itself is not counted toward a frame.
  - Err and Err_cnt never change in HUNT.
- State LOCKED:
  - Each accepted symbol does sym_idx++.
  - When sym_idx would reach DATA_NUM: sym_idx <= 0, pulse Frame_done, Frame_cnt++ (wraps).
  - A mismatched symbol still counts toward the frame.
  - Mismatch: pulse Err, Err_cnt++ saturating at all-ones, bad_run++.
  - Match: bad_run <= 0.
  - When bad_run would reach LOSS_THR: go to HUNT, Locked <= 0, pulse Lost, good_run <= 0, sym_idx <= 0.
  - The Err pulse for that final mismatch is still issued in the same cycle as Lost.
- Simultaneous events:
  - Frame completion and the loss transition on the same symbol: both Frame_done and Lost pulse.
  - Stop4calc=1 together with Valid=1: the symbol is dropped silently and Expected is not advanced. A gap in the sequence therefore appears when Stop4calc deasserts.
- Reset mid-operation: immediate return to reset values. Err_cnt and Frame_cnt clear; there is no retention.
- Counters are never cleared except by rstn.

Test Plan:
- Reset: hold rstn=0 for 5 cycles, drive Valid=1 with Data=0,1,2 -> all outputs stay 0; after release, Locked=1 one cycle after the 4th in-sequence symbol (LOCK_THR=4).
- Wrap and frame: lock on 0..3, then stream 4..15,0,1,2,3 -> Frame_done pulses exactly once, after the 16th post-lock symbol (Data=3 on the wrap); Frame_cnt=1; Err_cnt=0.
- Single error: locked stream 5,6,9,8,9 -> one Err pulse on the 9 in place of 7; Err_cnt=1; Locked stays 1; the following 8 is accepted as good.
- Loss of lock: locked, then inject 3 consecutive wrong symbols -> Err_cnt=3, Lost pulses together with the 3rd Err, Locked=0; re-lock after 4 fresh in-sequence symbols.
- Back-pressure: locked at Data=7, hold Stop4calc=1 while Data 8,9 are valid, release with Data=10 -> no change during the stall, then Err pulses on 10 (Expected still 8).
- Saturation: with CNT_SIZE=4, generate 20 isolated mismatches while locked -> Err_cnt stops at 15 and still pulses Err per mismatch.
